// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: per-stage enable/flush for load-use, mispredict and MDU stalls, plus perf counters.
// Latency: stage controls are combinational (same cycle); state, timeout, error flag and counters update at the next edge.
// Backpressure: holds PC/IF/ID/ID/EX while an MDU op is busy, releasing on done or on a bounded timeout.
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MDU_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_wb_load,
  input  logic [4:0]       ex_wb_rd,
  input  logic             ex_mispredict,
  input  logic             ex_mdu_start,
  input  logic             mdu_done,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mdu_busy,
  output logic             mdu_timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] load_use_count
);

  localparam int TW = $clog2(MDU_TIMEOUT);

  typedef enum logic {RUN = 1'b0, MDU_BUSY = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic          lu_hazard, mdu_stall, tmo_hit;
  logic          inc_flush, inc_lu, err_set;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Hazard detection: a load into x0 never creates a dependency.
  always_comb begin
    lu_hazard = ex_wb_load && (ex_wb_rd != 5'd0) &&
                ((id_uses_rs1 && (id_rs1 == ex_wb_rd)) ||
                 (id_uses_rs2 && (id_rs2 == ex_wb_rd)));
    mdu_stall = ex_mdu_start && !mdu_done;
    tmo_hit   = (tmo_cnt == TW'(MDU_TIMEOUT - 1));
  end

  assign mdu_busy = (state == MDU_BUSY);

  // Next-state and stage controls; reset forces the free-running RUN defaults.
  always_comb begin
    state_nxt    = state;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    inc_flush    = 1'b0;
    inc_lu       = 1'b0;
    err_set      = 1'b0;
    if (rst) begin
      case (state)
        RUN: begin
          if (ex_mispredict) begin
            // Redirect PC is loaded; the squashed ID instruction drops any load-use hazard.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            inc_flush   = 1'b1;
          end else if (mdu_stall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
            state_nxt    = MDU_BUSY;
          end else if (lu_hazard) begin
            // One bubble; the hazard disappears once the load moves past EX.
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            inc_lu      = 1'b1;
          end
        end
        MDU_BUSY: begin
          if (mdu_done || tmo_hit) begin
            state_nxt = RUN;
            err_set   = !mdu_done;
          end else begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // State, timeout counter, sticky error flag and saturating perf counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= RUN;
      tmo_cnt         <= '0;
      mdu_timeout_err <= 1'b0;
      stall_cycles    <= '0;
      flush_count     <= '0;
      load_use_count  <= '0;
    end else begin
      state           <= state_nxt;
      tmo_cnt         <= (state == RUN) ? '0 : tmo_cnt + TW'(1);
      mdu_timeout_err <= mdu_timeout_err | err_set;
      if (!pc_en)    stall_cycles   <= sat_inc(stall_cycles);
      if (inc_flush) flush_count    <= sat_inc(flush_count);
      if (inc_lu)    load_use_count <= sat_inc(load_use_count);
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline register chain: IF stage/PC, IF/ID, ID/EX and EX/MEM.
- Produces per-stage enable and flush controls for three hazard sources:
  - load-use hazards;
  - branch/jump mispredict redirects;
  - multi-cycle multiply/divide (MDU) operations in EX.
- Keeps saturating performance counters for the benchmarking flow.
- Sits beside the ID/EX pipeline register and drives its pipeline_en and pipeline_flush inputs.

Parameters:
- CNT_W, 32, width of each performance counter.
- MDU_TIMEOUT, 64, maximum cycles in MDU_BUSY before forced release; must be at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- id_rs1  in  5  rs1 of the instruction in ID.
- id_rs2  in  5  rs2 of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_wb_load  in  1  EX instruction is a load.
- ex_wb_rd  in  5  destination register of the EX instruction.
- ex_mispredict  in  1  branch resolved in EX disagrees with prediction.
- ex_mdu_start  in  1  EX holds a valid multi-cycle MDU op.
- mdu_done  in  1  MDU result valid this cycle.
- pc_en  out  1  PC update enable.
- if_id_en  out  1  IF/ID enable.
- if_id_flush  out  1  IF/ID bubble insert.
- id_ex_en  out  1  ID/EX enable.
- id_ex_flush  out  1  ID/EX bubble insert.
- ex_mem_flush  out  1  EX/MEM bubble insert.
- mdu_busy  out  1  state == MDU_BUSY.
- mdu_timeout_err  out  1  sticky error flag, set on timeout.
- stall_cycles  out  CNT_W  cycles with pc_en = 0.
- flush_count  out  CNT_W  mispredict redirects taken.
- load_use_count  out  CNT_W  load-use bubbles inserted.

Behaviour:
- State, the timeout counter, the error flag and the perf counters are registered. Stage controls are combinational from the current state and inputs, so they take effect in the same cycle.
- Reset (rst = 0 at a clock edge) forces:
  - state = RUN;
  - timeout counter = 0, mdu_timeout_err = 0, all counters = 0.
  - While reset is held, the stage controls are forced to their RUN defaults (pc_en = if_id_en = id_ex_en = 1, all flushes = 0).
  - Reset mid-MDU_BUSY is an immediate abort.
- RUN defaults: all enables = 1, all flushes = 0.
- lu_hazard = ex_wb_load & (ex_wb_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_wb_rd) | (id_uses_rs2 & id_rs2 == ex_wb_rd)).
- mdu_stall = ex_mdu_start & !mdu_done.
- Priority in RUN, highest first: ex_mispredict > mdu_stall > lu_hazard.
- Mispredict (RUN):
  - pc_en = 1 (redirect is loaded); if_id_flush = 1; id_ex_flush = 1.
  - flush_count increments.
  - Any coincident lu_hazard is discarded, because its ID instruction is squashed.
- mdu_stall (RUN):
  - pc_en = if_id_en = id_ex_en = 0; ex_mem_flush = 1.
  - Next state = MDU_BUSY; timeout counter is cleared to 0.
- ex_mdu_start with mdu_done in the same cycle: no stall, no state change.
- Load-use (RUN, no higher event):
  - pc_en = if_id_en = 0; id_ex_flush = 1.
  - load_use_count increments.
  - Exactly one bubble is inserted; the hazard clears naturally once the load leaves EX.
- MDU_BUSY:
  - pc_en = if_id_en = id_ex_en = 0; ex_mem_flush = 1.
  - ex_mispredict and lu_hazard are ignored.
  - Timeout counter increments every cycle.
  - mdu_done = 1: this cycle releases (all enables = 1, ex_mem_flush = 0); next state = RUN.
  - Timeout counter reaches MDU_TIMEOUT - 1 without done:
    - mdu_timeout_err is set (sticky until reset);
    - this cycle releases as for mdu_done; next state = RUN.
- stall_cycles increments in every cycle where pc_en = 0.
- All counters saturate at all-ones; no wrap-around.
- Invariant: a stage is never both enabled-to-hold and flushed. A flush always overrides the matching enable inside the pipeline register.

Test Plan:
- Reset: hold rst = 0 for 2 cycles with ex_mispredict = 1 -> pc_en = 1, no flush, all counters 0; after release, state RUN.
- Load-use: ex_wb_load = 1, ex_wb_rd = 5, id_rs1 = 5, id_uses_rs1 = 1 for one cycle -> pc_en = 0, if_id_en = 0, id_ex_flush = 1 for exactly 1 cycle; load_use_count = 1, stall_cycles = 1. Repeat with ex_wb_rd = 0 -> no stall.
- Mispredict plus load-use in the same cycle -> if_id_flush = id_ex_flush = 1, pc_en = 1; flush_count = 1, load_use_count unchanged.
- MDU: ex_mdu_start = 1, mdu_done asserted 4 cycles later -> mdu_busy = 1 for 4 cycles; pc_en = 0 for 4 cycles, released in the done cycle; stall_cycles = 4. Same-cycle start and done -> no stall.
- Timeout with MDU_TIMEOUT = 8 and mdu_done never asserted -> forced release on the 8th cycle after the start cycle; mdu_timeout_err = 1 and stays 1; state RUN.
- Saturation with CNT_W = 4: 20 load-use events -> load_use_count = 15 and stays 15.
